// File: rtl/upc_pkg.sv
// upc_pkg: shared state type, default lookup masks and item classifier for the checkout monitor
package upc_pkg;

    typedef enum logic {IDLE, ALARM} upc_state_e;

    localparam logic [15:0] DISC_MASK_DEF = 16'h0035;
    localparam logic [15:0] EXP_MASK_DEF  = 16'hF000;

    // Masks are passed zero-extended to 256 bits so any code width up to 8 fits
    function automatic logic [1:0] classify(
        input logic [7:0]   code,
        input logic         marked,
        input logic [255:0] disc_mask,
        input logic [255:0] exp_mask
    );
        return {disc_mask[code], exp_mask[code] & ~marked};
    endfunction

endpackage

// File: rtl/upc_checkout_sat_counter.sv
// sat_counter: up-counter with enable and synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= clr ? '0 : (en && cnt != '1) ? cnt + 1'b1 : cnt;

endmodule

// File: rtl/upc_checkout.sv
// upc_checkout: checkout-station monitor classifying scanned items and locking out scans
//               for a timed alarm after a theft
module upc_checkout
    import upc_pkg::*;
#(
    parameter int                   CODE_W    = 4,
    parameter int                   CNT_W     = 8,
    parameter logic [2**CODE_W-1:0] DISC_MASK = DISC_MASK_DEF,
    parameter logic [2**CODE_W-1:0] EXP_MASK  = EXP_MASK_DEF,
    parameter int                   ALARM_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_valid,
    input  logic [CODE_W-1:0] scan_code,
    input  logic              scan_marked,
    output logic              scan_ready,
    input  logic              alarm_clr,
    input  logic              cnt_clr,
    output logic              discount,
    output logic              stolen,
    output logic              alarm,
    output logic [CODE_W-1:0] last_code,
    output logic [CNT_W-1:0]  item_cnt,
    output logic [CNT_W-1:0]  disc_cnt,
    output logic [CNT_W-1:0]  theft_cnt
);

    localparam int HW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(ALARM_CYC - 1);

    upc_state_e    state, state_nx;
    logic [HW-1:0] hold;
    logic [1:0]    cls;
    logic          accept, disc, theft;

    assign cls        = classify(8'(scan_code), scan_marked, 256'(DISC_MASK), 256'(EXP_MASK));
    assign disc       = cls[1];
    assign theft      = cls[0];
    assign scan_ready = state == IDLE;
    assign alarm      = state == ALARM;
    assign accept     = scan_valid && scan_ready;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? ((accept && theft) ? ALARM : IDLE)
                                   : ((hold == '0 || alarm_clr) ? IDLE : ALARM);
    end

    // hold is only meaningful in ALARM; the wrap on exit is overwritten in IDLE
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            hold      <= '0;
            discount  <= 1'b0;
            stolen    <= 1'b0;
            last_code <= '0;
        end else begin
            state     <= state_nx;
            hold      <= (state == IDLE) ? ((accept && theft) ? HOLD_LOAD : '0) : hold - 1'b1;
            discount  <= accept && disc;
            stolen    <= accept && theft;
            last_code <= (accept && theft) ? scan_code : last_code;
        end

    sat_counter #(.W(CNT_W)) u_item (
        .clk(clk), .reset_n(reset_n), .en(accept), .clr(cnt_clr), .cnt(item_cnt)
    );

    sat_counter #(.W(CNT_W)) u_disc (
        .clk(clk), .reset_n(reset_n), .en(accept && disc), .clr(cnt_clr), .cnt(disc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_theft (
        .clk(clk), .reset_n(reset_n), .en(accept && theft), .clr(cnt_clr), .cnt(theft_cnt)
    );

endmodule

// File: tb/tb_upc_checkout.sv
// tb_upc_checkout: directed plus random scans against a reference model, on a default
//                  8-bit-counter instance and a 4-bit-counter instance sharing stimulus
module tb_upc_checkout;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic [3:0] scan_code = '0;
    logic       scan_marked = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       scan_ready, discount, stolen, alarm;
    logic [3:0] last_code;
    logic [7:0] item_cnt, disc_cnt, theft_cnt;
    logic       scan_ready4, discount4, stolen4, alarm4;
    logic [3:0] last_code4;
    logic [3:0] item_cnt4, disc_cnt4, theft_cnt4;

    int total = 0;
    int bad = 0;

    int m_items, m_disc, m_theft, m_left, m_last;
    logic m_dp, m_sp;

    always #5 clk = ~clk;

    upc_checkout dut (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_code(scan_code),
        .scan_marked(scan_marked), .scan_ready(scan_ready), .alarm_clr(alarm_clr),
        .cnt_clr(cnt_clr), .discount(discount), .stolen(stolen), .alarm(alarm),
        .last_code(last_code), .item_cnt(item_cnt), .disc_cnt(disc_cnt), .theft_cnt(theft_cnt)
    );

    upc_checkout #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_code(scan_code),
        .scan_marked(scan_marked), .scan_ready(scan_ready4), .alarm_clr(alarm_clr),
        .cnt_clr(cnt_clr), .discount(discount4), .stolen(stolen4), .alarm(alarm4),
        .last_code(last_code4), .item_cnt(item_cnt4), .disc_cnt(disc_cnt4), .theft_cnt(theft_cnt4)
    );

    function automatic int sat(input int x, input int mx);
        return x > mx ? mx : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_items = 0; m_disc = 0; m_theft = 0; m_left = 0; m_last = 0;
        m_dp = 1'b0; m_sp = 1'b0;
    endtask

    task automatic check_all();
        chk("ready", 32'(scan_ready), 32'(m_left == 0));
        chk("alarm", 32'(alarm), 32'(m_left > 0));
        chk("discount", 32'(discount), 32'(m_dp));
        chk("stolen", 32'(stolen), 32'(m_sp));
        chk("last_code", 32'(last_code), 32'(m_last));
        chk("item_cnt", 32'(item_cnt), 32'(sat(m_items, 255)));
        chk("disc_cnt", 32'(disc_cnt), 32'(sat(m_disc, 255)));
        chk("theft_cnt", 32'(theft_cnt), 32'(sat(m_theft, 255)));
        chk("alarm4", 32'(alarm4), 32'(m_left > 0));
        chk("ready4", 32'(scan_ready4), 32'(m_left == 0));
        chk("discount4", 32'(discount4), 32'(m_dp));
        chk("stolen4", 32'(stolen4), 32'(m_sp));
        chk("last_code4", 32'(last_code4), 32'(m_last));
        chk("item_cnt4", 32'(item_cnt4), 32'(sat(m_items, 15)));
        chk("disc_cnt4", 32'(disc_cnt4), 32'(sat(m_disc, 15)));
        chk("theft_cnt4", 32'(theft_cnt4), 32'(sat(m_theft, 15)));
    endtask

    // One clock: drive inputs, predict from the rules, then compare after the edge
    task automatic step(input logic v, input logic [3:0] c, input logic mk,
                        input logic ac, input logic cc);
        logic acc, d, t;
        scan_valid = v; scan_code = c; scan_marked = mk; alarm_clr = ac; cnt_clr = cc;
        acc = v && (m_left == 0);
        d = (c == 0) || (c == 2) || (c == 4) || (c == 5);
        t = (c >= 12) && !mk;
        @(posedge clk);
        #1;
        if (cc) begin
            m_items = 0; m_disc = 0; m_theft = 0;
        end else if (acc) begin
            m_items++;
            if (d) m_disc++;
            if (t) m_theft++;
        end
        m_dp = acc && d;
        m_sp = acc && t;
        if (acc && t) m_last = int'(c);
        if (m_left == 0) begin
            if (acc && t) m_left = 16;
        end else
            m_left = ac ? 0 : m_left - 1;
        check_all();
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // every code once, all marked: only the four discount codes pulse
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("plan1_items", 32'(item_cnt), 32'd16);
        chk("plan1_disc", 32'(disc_cnt), 32'd4);

        // unmarked expensive item, then a held scan during the full alarm
        step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (alarm === 1'b1 && n < 40) begin
            n++;
            step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        end
        chk("alarm_len", 32'(n), 32'd16);
        chk("plan2_theft", 32'(theft_cnt), 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // early clear on the third alarm cycle
        step(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        // alarm_clr in IDLE is harmless
        step(1'b1, 4'd2, 1'b1, 1'b1, 1'b0);

        // saturation of the narrow counters, then clear coincident with an accepted scan
        for (int i = 0; i < 20; i++) step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("sat4_items", 32'(item_cnt4), 32'd15);
        step(1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
        chk("clr_items", 32'(item_cnt), 32'd0);

        // asynchronous reset while in ALARM
        step(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
